// File: rtl/approx_mult_controller_if.sv
// Control/status bundle between the approximate-multiplier sequencer and the
// datapath plus top-level start/done handshake.
// master: sequencer side. slave: datapath / top-level side.
interface approx_mult_controller_if;
  // handshake and datapath status into the sequencer
  logic start;
  logic DoneA;
  logic DoneB;
  logic down_done;
  // datapath control pins and status out of the sequencer
  logic loadA;
  logic loadB;
  logic ShlA;
  logic ShlB;
  logic rst5;
  logic cntU;
  logic cntD;
  logic loadOut;
  logic ShrOut;
  logic busy;
  logic done;
  logic zero_op;

  modport master (
    input  start, DoneA, DoneB, down_done,
    output loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut,
           busy, done, zero_op
  );

  modport slave (
    output start, DoneA, DoneB, down_done,
    input  loadA, loadB, ShlA, ShlB, rst5, cntU, cntD, loadOut, ShrOut,
           busy, done, zero_op
  );
endinterface

// File: rtl/approx_mult_controller.sv
// Sequencing FSM for the 16x16 approximate multiplier.
// Loads A/B, left-normalises each operand while counting shifts in the
// datapath 5-bit counter, multiplies the top bytes, then right-shifts the
// product once per counted shift.
// Optional feature: define MULT_CTRL_ZERO_GUARD_EN to bound normalisation of
// a zero operand to MAX_SHIFT shifts and flag it on zero_op. Without it a
// zero operand parks the FSM in NORM_A/NORM_B until reset.
module approx_mult_controller #(
  parameter int MAX_SHIFT = 15,
  parameter int GUARD_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  approx_mult_controller_if.master    bus
);

  // guard counter must be able to hold MAX_SHIFT
  if (GUARD_W < $clog2(MAX_SHIFT + 1)) begin : g_param_check
    $error("GUARD_W too narrow for MAX_SHIFT");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_NORM_A = 3'd2,
    S_NORM_B = 3'd3,
    S_MULT   = 3'd4,
    S_SHR    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_loadA;
  logic w_loadB;
  logic w_ShlA;
  logic w_ShlB;
  logic w_rst5;
  logic w_cntU;
  logic w_cntD;
  logic w_loadOut;
  logic w_ShrOut;
  logic w_accept;

`ifdef MULT_CTRL_ZERO_GUARD_EN
  logic [GUARD_W-1:0] r_guard;
  logic [GUARD_W-1:0] w_guard_nxt;
  logic               w_guard_max;
  logic               w_set_zero;
  logic               r_zero_op;

  assign w_guard_max = (r_guard == GUARD_W'(MAX_SHIFT));
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state and Mealy control decode
  always_comb begin
    w_next    = r_state;
    w_loadA   = 1'b0;
    w_loadB   = 1'b0;
    w_ShlA    = 1'b0;
    w_ShlB    = 1'b0;
    w_rst5    = 1'b0;
    w_cntU    = 1'b0;
    w_cntD    = 1'b0;
    w_loadOut = 1'b0;
    w_ShrOut  = 1'b0;
`ifdef MULT_CTRL_ZERO_GUARD_EN
    w_guard_nxt = r_guard;
    w_set_zero  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_loadA = 1'b1;
        w_loadB = 1'b1;
        w_rst5  = 1'b1;
`ifdef MULT_CTRL_ZERO_GUARD_EN
        w_guard_nxt = '0;
`endif
        w_next  = S_NORM_A;
      end
      S_NORM_A: begin
        if (bus.DoneA) begin
`ifdef MULT_CTRL_ZERO_GUARD_EN
          w_guard_nxt = '0;
`endif
          w_next = S_NORM_B;
`ifdef MULT_CTRL_ZERO_GUARD_EN
        end else if (w_guard_max) begin
          // operand is zero: stop shifting and treat it as normalised
          w_guard_nxt = '0;
          w_set_zero  = 1'b1;
          w_next      = S_NORM_B;
`endif
        end else begin
          w_ShlA = 1'b1;
          w_cntU = 1'b1;
`ifdef MULT_CTRL_ZERO_GUARD_EN
          w_guard_nxt = r_guard + 1'b1;
`endif
        end
      end
      S_NORM_B: begin
        if (bus.DoneB) begin
`ifdef MULT_CTRL_ZERO_GUARD_EN
          w_guard_nxt = '0;
`endif
          w_next = S_MULT;
`ifdef MULT_CTRL_ZERO_GUARD_EN
        end else if (w_guard_max) begin
          w_guard_nxt = '0;
          w_set_zero  = 1'b1;
          w_next      = S_MULT;
`endif
        end else begin
          w_ShlB = 1'b1;
          w_cntU = 1'b1;
`ifdef MULT_CTRL_ZERO_GUARD_EN
          w_guard_nxt = r_guard + 1'b1;
`endif
        end
      end
      S_MULT: begin
        w_loadOut = 1'b1;
        w_next    = S_SHR;
      end
      S_SHR: begin
        // undo the normalisation one bit per counted shift
        if (bus.down_done) begin
          w_next = S_DONE;
        end else begin
          w_ShrOut = 1'b1;
          w_cntD   = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef MULT_CTRL_ZERO_GUARD_EN
  // per-operand guard counter and sticky zero-operand flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_guard   <= '0;
      r_zero_op <= 1'b0;
    end else begin
      r_guard <= w_guard_nxt;
      if (w_accept) begin
        r_zero_op <= 1'b0;
      end else if (w_set_zero) begin
        r_zero_op <= 1'b1;
      end
    end
  end

  assign bus.zero_op = r_zero_op;
`else
  assign bus.zero_op = 1'b0;
`endif

  assign bus.loadA   = w_loadA;
  assign bus.loadB   = w_loadB;
  assign bus.ShlA    = w_ShlA;
  assign bus.ShlB    = w_ShlB;
  assign bus.rst5    = w_rst5;
  assign bus.cntU    = w_cntU;
  assign bus.cntD    = w_cntD;
  assign bus.loadOut = w_loadOut;
  assign bus.ShrOut  = w_ShrOut;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);

endmodule

// File: tb/tb_approx_mult_controller.sv
// Directed bench for approx_mult_controller with a behavioural datapath
// (A/B shift registers, 5-bit shift counter, result register).
// Guard-specific vectors run when MULT_CTRL_ZERO_GUARD_EN is defined.
module tb_approx_mult_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  approx_mult_controller_if bus ();

  approx_mult_controller #(
    .MAX_SHIFT (15),
    .GUARD_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // datapath model
  logic [15:0] opA, opB;
  logic [15:0] m_a, m_b, m_res;
  logic [4:0]  m_cnt;

  always_ff @(posedge clk) begin
    if (bus.loadA) m_a <= opA;
    else if (bus.ShlA) m_a <= m_a << 1;
    if (bus.loadB) m_b <= opB;
    else if (bus.ShlB) m_b <= m_b << 1;
    if (bus.rst5) m_cnt <= 5'd0;
    else if (bus.cntU) m_cnt <= m_cnt + 5'd1;
    else if (bus.cntD) m_cnt <= m_cnt - 5'd1;
    if (bus.loadOut) m_res <= m_a[15:8] * m_b[15:8];
    else if (bus.ShrOut) m_res <= m_res >> 1;
  end

  assign bus.DoneA     = m_a[15];
  assign bus.DoneB     = m_b[15];
  assign bus.down_done = (m_cnt == 5'd0);

  // activity monitor: running event counts and invariant violations
  int c_shla = 0, c_shlb = 0, c_cntu = 0, c_cntd = 0;
  int c_shr = 0, c_ldo = 0, c_done = 0, c_viol = 0;

  always @(negedge clk) begin
    if (!rst) begin
      c_shla += int'(bus.ShlA);
      c_shlb += int'(bus.ShlB);
      c_cntu += int'(bus.cntU);
      c_cntd += int'(bus.cntD);
      c_shr  += int'(bus.ShrOut);
      c_ldo  += int'(bus.loadOut);
      c_done += int'(bus.done);
      if (bus.cntU && bus.cntD) c_viol++;
      if (bus.loadA && bus.ShlA) c_viol++;
      if (bus.loadB && bus.ShlB) c_viol++;
      if (bus.cntU && m_cnt == 5'd31) c_viol++;
      if (bus.cntD && m_cnt == 5'd0) c_viol++;
    end
  end

  int b_shla, b_shlb, b_cntu, b_cntd, b_shr, b_ldo, b_done, b_viol;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [11:0] all_outs();
    return {bus.loadA, bus.loadB, bus.ShlA, bus.ShlB, bus.rst5, bus.cntU,
            bus.cntD, bus.loadOut, bus.ShrOut, bus.busy, bus.done, bus.zero_op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_shla = c_shla; b_shlb = c_shlb; b_cntu = c_cntu; b_cntd = c_cntd;
    b_shr  = c_shr;  b_ldo  = c_ldo;  b_done = c_done; b_viol = c_viol;
  endtask

  // one operation from an idle FSM: returns cycles from accept edge to done inclusive
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    opA = a;
    opB = b;
    @(negedge clk);
    snap();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
    end
    @(negedge clk);
  endtask

  int lat, p;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    opA = 16'h0;
    opB = 16'h0;

    // reset state
    #12;
    check("outs_in_reset", {20'd0, all_outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("outs_after_reset", {20'd0, all_outs()}, 32'd0);

    // both operands already normalised
    run_op(16'h8000, 16'h8000, lat);
    check("t1_latency", lat, 6);
    check("t1_shla", c_shla - b_shla, 0);
    check("t1_shlb", c_shlb - b_shlb, 0);
    check("t1_loadout", c_ldo - b_ldo, 1);
    check("t1_shrout", c_shr - b_shr, 0);
    check("t1_done_pulses", c_done - b_done, 1);
    check("t1_result", m_res, 16'h4000);
    check("t1_zero_op", bus.zero_op, 1'b0);

    // maximum non-zero normalisation
    run_op(16'h0001, 16'h0100, lat);
    check("t2_latency", lat, 50);
    check("t2_shla", c_shla - b_shla, 15);
    check("t2_shlb", c_shlb - b_shlb, 7);
    check("t2_cntu", c_cntu - b_cntu, 22);
    check("t2_cntd", c_cntd - b_cntd, 22);
    check("t2_shrout", c_shr - b_shr, 22);
    check("t2_viol", c_viol - b_viol, 0);
    check("t2_busy_after", bus.busy, 1'b0);

    // start pulses while busy are ignored
    opA = 16'h0001;
    opB = 16'h0100;
    @(negedge clk);
    snap();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == 3) || (lat == 10);
      if (bus.done) break;
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("t3_latency", lat, 50);
    check("t3_done_pulses", c_done - b_done, 1);
    check("t3_busy_after", bus.busy, 1'b0);

    // reset during SHR
    opA = 16'h0001;
    opB = 16'h0100;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    p = 0;
    while (p < 200 && !bus.ShrOut) begin
      @(negedge clk);
      p++;
    end
    check("t4_reached_shr", bus.ShrOut, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t4_outs_in_rst", {20'd0, all_outs()}, 32'd0);
    check("t4_busy_in_rst", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h4000, 16'h8000, lat);
    check("t4_latency_after", lat, 8);
    check("t4_shla_after", c_shla - b_shla, 1);
    check("t4_result_after", m_res, 16'h2000);

    // start held high: back-to-back operations
    opA = 16'h8000;
    opB = 16'h4000;
    @(negedge clk);
    snap();
    bus.start = 1'b1;
    p = 0;
    while (p < 100 && !bus.done) begin
      @(negedge clk);
      p++;
    end
    check("t5_first_done", bus.done, 1'b1);
    for (int k = 0; k < 2; k++) begin
      p = 0;
      while (p < 100) begin
        @(negedge clk);
        p++;
        if (bus.done) break;
      end
      check("t5_period", p, 9);
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_busy_after", bus.busy, 1'b0);
    check("t5_result", m_res, 16'h2000);
    check("t5_viol", c_viol - b_viol, 0);

`ifdef MULT_CTRL_ZERO_GUARD_EN
    // zero operand A aborted by the guard
    run_op(16'h0000, 16'h8000, lat);
    check("g1_latency", lat, 36);
    check("g1_shla", c_shla - b_shla, 15);
    check("g1_shlb", c_shlb - b_shlb, 0);
    check("g1_zero_op", bus.zero_op, 1'b1);
    check("g1_result", m_res, 16'h0000);

    // zero operand B aborted by the guard
    run_op(16'h8000, 16'h0000, lat);
    check("g2_latency", lat, 36);
    check("g2_shlb", c_shlb - b_shlb, 15);
    check("g2_zero_op", bus.zero_op, 1'b1);

    // zero_op cleared by the next accepted start
    run_op(16'h8000, 16'h8000, lat);
    check("g3_latency", lat, 6);
    check("g3_zero_op", bus.zero_op, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
